pc_fetch_ctrl: RTL and testbench

IF-stage program-counter and instruction-fetch controller. It consumes the `branch_flag`/`branch_addr` redirect produced by branch resolution in ID, with MIPS one-instruction delay-slot semantics. It drives the instruction ROM request and delivers registered `{valid, addr, inst}` to the IF/ID boundary. It handles ROM wait states, downstream stalls, and redirects that arrive while a fetch is still outstanding.

---
 rtl/pc_fetch_ctrl_pkg.sv | 14 +
 rtl/pc_fetch_ctrl_next_sel.sv | 21 ++
 rtl/pc_fetch_ctrl.sv | 92 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: bus widths, fetch FSM states and reset PC shared by pc_fetch_ctrl.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef INST_BUS
`define INST_BUS 31:0
`endif
package pc_fetch_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/pc_fetch_ctrl_next_sel.sv
// pc_next_sel: next-PC priority mux (exception when FETCH_EXCEPT_EN, pending redirect, live branch, pc+4).
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
(
  input  logic             pend_valid,
  input  logic [`ADDR_BUS] pend_addr,
  input  logic             branch_flag,
  input  logic [`ADDR_BUS] branch_addr,
`ifdef FETCH_EXCEPT_EN
  input  logic             exc_flag,
  input  logic [`ADDR_BUS] exc_addr,
`endif
  input  logic [`ADDR_BUS] pc,
  output logic [`ADDR_BUS] next_pc
);
`ifdef FETCH_EXCEPT_EN
  assign next_pc = exc_flag ? exc_addr : pend_valid ? pend_addr : branch_flag ? branch_addr : pc_inc(pc);
`else
  assign next_pc = pend_valid ? pend_addr : branch_flag ? branch_addr : pc_inc(pc);
`endif
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: IF-stage PC and ROM fetch controller with delay-slot redirects.
// FETCH_EXCEPT_EN adds exc_flag/exc_addr for an exception redirect.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_flag,
  input  logic [`ADDR_BUS] branch_addr,
  input  logic             rom_ready,
  input  logic [`INST_BUS] rom_data,
`ifdef FETCH_EXCEPT_EN
  input  logic             exc_flag,
  input  logic [`ADDR_BUS] exc_addr,
`endif
  output logic             rom_en,
  output logic [`ADDR_BUS] rom_addr,
  output logic             if_valid,
  output logic [`ADDR_BUS] if_addr,
  output logic [`INST_BUS] if_inst,
  output logic             fetch_stall
);
  state_t state, state_n;
  logic [`ADDR_BUS] pc, pc_n, next_pc, pend, pend_n, if_addr_n;
  logic [`INST_BUS] hold_buf, hold_buf_n, if_inst_n;
  logic pend_v, pend_v_n, if_valid_n, adv, take, exc;
`ifdef FETCH_EXCEPT_EN
  assign exc = exc_flag;
`else
  assign exc = 1'b0;
`endif
  pc_next_sel u_sel (
    .pend_valid (pend_v),
    .pend_addr  (pend),
    .branch_flag(branch_flag),
    .branch_addr(branch_addr),
`ifdef FETCH_EXCEPT_EN
    .exc_flag   (exc_flag),
    .exc_addr   (exc_addr),
`endif
    .pc         (pc),
    .next_pc    (next_pc)
  );
  // adv: an instruction is handed to ID this cycle, so pc moves on
  always_comb begin
    adv = ~stall & ((state == FETCH & rom_ready) | state == HOLD);
    take = ~stall & branch_flag & ~adv;
    state_n = state == IDLE ? FETCH : state == FETCH ? (rom_ready & stall ? HOLD : FETCH) : (stall ? HOLD : FETCH);
    pc_n = adv ? next_pc : pc;
    pend_v_n = ~adv & (take | pend_v);
    pend_n = adv ? '0 : take ? branch_addr : pend;
    hold_buf_n = (state == FETCH & rom_ready & stall) ? rom_data : hold_buf;
    if_valid_n = adv | (if_valid & (stall | state != FETCH));
    if_addr_n = adv ? pc : if_addr;
    if_inst_n = adv ? (state == HOLD ? hold_buf : rom_data) : if_inst;
    if (exc) begin
      state_n = FETCH;
      pc_n = next_pc;
      pend_v_n = 1'b0;
      pend_n = '0;
      hold_buf_n = '0;
      if_valid_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      pend_v <= 1'b0;
      pend <= '0;
      hold_buf <= '0;
      if_valid <= 1'b0;
      if_addr <= '0;
      if_inst <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pend_v <= pend_v_n;
      pend <= pend_n;
      hold_buf <= hold_buf_n;
      if_valid <= if_valid_n;
      if_addr <= if_addr_n;
      if_inst <= if_inst_n;
    end
  end
  assign rom_en = state == FETCH;
  assign rom_addr = pc;
  assign fetch_stall = rom_en & ~rom_ready;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed bench with a cycle model of the fetch stream and literal spot checks.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic branch_flag = 1'b0;
  logic rom_ready = 1'b1;
  logic [31:0] branch_addr = '0;
  logic [31:0] rom_data;
  logic rom_en, if_valid, fetch_stall;
  logic [31:0] rom_addr, if_addr, if_inst;
`ifdef FETCH_EXCEPT_EN
  logic exc_flag = 1'b0;
  logic [31:0] exc_addr = '0;
`endif
  int total = 0;
  int bad = 0;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branch_flag(branch_flag),
    .branch_addr(branch_addr),
    .rom_ready  (rom_ready),
    .rom_data   (rom_data),
`ifdef FETCH_EXCEPT_EN
    .exc_flag   (exc_flag),
    .exc_addr   (exc_addr),
`endif
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .if_valid   (if_valid),
    .if_addr    (if_addr),
    .if_inst    (if_inst),
    .fetch_stall(fetch_stall)
  );

  always #5 clk = ~clk;
  assign rom_data = rom_addr ^ KEY;

  function automatic logic [31:0] romf(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: fetch stream as "started / holding one word / queued redirect"
  logic m_init = 1'b0;
  logic m_started, m_held, m_iv;
  logic [31:0] m_pc, m_hi, m_ia, m_ii;
  logic [31:0] m_redir[$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_init = 1'b1;
      m_started = 1'b0;
      m_held = 1'b0;
      m_hi = '0;
      m_pc = RST_PC;
      m_redir.delete();
      m_iv = 1'b0;
      m_ia = '0;
      m_ii = '0;
    end
`ifdef FETCH_EXCEPT_EN
    else if (exc_flag) begin
      m_pc = exc_addr;
      m_redir.delete();
      m_held = 1'b0;
      m_iv = 1'b0;
      m_started = 1'b1;
    end
`endif
    else if (!m_started) begin
      m_started = 1'b1;
      if (!stall && branch_flag) begin
        m_redir.delete();
        m_redir.push_back(branch_addr);
      end
    end else if (!stall && (m_held || rom_ready)) begin
      m_iv = 1'b1;
      m_ia = m_pc;
      m_ii = m_held ? m_hi : romf(m_pc);
      m_held = 1'b0;
      m_pc = m_redir.size() > 0 ? m_redir.pop_front() : branch_flag ? branch_addr : m_pc + 32'd4;
      m_redir.delete();
    end else if (!stall) begin
      m_iv = 1'b0;
      if (branch_flag) begin
        m_redir.delete();
        m_redir.push_back(branch_addr);
      end
    end else if (!m_held && rom_ready) begin
      m_held = 1'b1;
      m_hi = romf(m_pc);
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("m_rom_en", rom_en, m_started & ~m_held);
      chk("m_rom_addr", rom_addr, m_pc);
      chk("m_fetch_stall", fetch_stall, m_started & ~m_held & ~rom_ready);
      chk("m_if_valid", if_valid, m_iv);
      chk("m_if_addr", if_addr, m_ia);
      chk("m_if_inst", if_inst, m_ii);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    branch_flag = 1'b0;
    rom_ready = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    #1;
    chk("rst_rom_en", rom_en, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_addr", if_addr, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_rom_addr", rom_addr, RST_PC);
  endtask

  initial begin
    // zero-wait sequential fetch
    do_reset();
    nxt(); #1;
    chk("seq_first_en", rom_en, 1);
    chk("seq_addr0", rom_addr, 32'hBFC0_0000);
    chk("seq_valid0", if_valid, 0);
    nxt(); #1;
    chk("seq_addr1", rom_addr, 32'hBFC0_0004);
    chk("seq_if_addr0", if_addr, 32'hBFC0_0000);
    chk("seq_valid1", if_valid, 1);
    nxt(); #1;
    chk("seq_addr2", rom_addr, 32'hBFC0_0008);
    chk("seq_if_addr1", if_addr, 32'hBFC0_0004);
    chk("seq_if_inst1", if_inst, 32'hBFC0_0004 ^ KEY);
    // branch with delay slot, zero-wait
    do_reset();
    nxt(); nxt();
    branch_flag = 1'b1;
    branch_addr = 32'hBFC0_0100;
    nxt();
    branch_flag = 1'b0;
    #1;
    chk("br_slot_addr", if_addr, 32'hBFC0_0004);
    chk("br_target_pc", rom_addr, 32'hBFC0_0100);
    nxt(); #1;
    chk("br_target_if", if_addr, 32'hBFC0_0100);
    chk("br_after", rom_addr, 32'hBFC0_0104);
    // redirect while the delay slot waits on the ROM
    do_reset();
    nxt(); nxt();
    branch_flag = 1'b1;
    branch_addr = 32'hBFC0_0100;
    rom_ready = 1'b0;
    #1;
    chk("wait_fs1", fetch_stall, 1);
    nxt();
    branch_flag = 1'b0;
    #1;
    chk("wait_fs2", fetch_stall, 1);
    chk("wait_bubble", if_valid, 0);
    chk("wait_pc_held", rom_addr, 32'hBFC0_0004);
    nxt(); #1;
    chk("wait_fs3", fetch_stall, 1);
    nxt();
    rom_ready = 1'b1;
    #1;
    chk("wait_fs_clear", fetch_stall, 0);
    nxt(); #1;
    chk("wait_slot", if_addr, 32'hBFC0_0004);
    chk("wait_target", rom_addr, 32'hBFC0_0100);
    // downstream stall with data ready
    do_reset();
    nxt(); nxt(); nxt();
    stall = 1'b1;
    #1;
    chk("st_pc", rom_addr, 32'hBFC0_0008);
    nxt(); #1;
    chk("st_hold_en", rom_en, 0);
    chk("st_frozen", if_addr, 32'hBFC0_0004);
    chk("st_frozen_v", if_valid, 1);
    nxt();
    stall = 1'b0;
    nxt(); #1;
    chk("st_deliver", if_addr, 32'hBFC0_0008);
    chk("st_deliver_inst", if_inst, 32'hBFC0_0008 ^ KEY);
    chk("st_next_pc", rom_addr, 32'hBFC0_000C);
    nxt(); #1;
    chk("st_no_dup", if_addr, 32'hBFC0_000C);
    // wrap, then reset while holding with a pending redirect
    do_reset();
    nxt(); nxt();
    branch_flag = 1'b1;
    branch_addr = 32'hFFFF_FFF8;
    nxt();
    branch_flag = 1'b0;
    nxt(); #1;
    chk("wrap_top", rom_addr, 32'hFFFF_FFFC);
    nxt(); #1;
    chk("wrap_zero", rom_addr, 32'h0000_0000);
    chk("wrap_if", if_addr, 32'hFFFF_FFFC);
    branch_flag = 1'b1;
    branch_addr = 32'hBFC0_0200;
    rom_ready = 1'b0;
    nxt();
    branch_flag = 1'b0;
    rom_ready = 1'b1;
    stall = 1'b1;
    nxt(); #1;
    chk("rh_hold", rom_en, 0);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    stall = 1'b0;
    #1;
    chk("rh_en", rom_en, 0);
    chk("rh_valid", if_valid, 0);
    chk("rh_if_addr", if_addr, 0);
    chk("rh_if_inst", if_inst, 0);
    chk("rh_pc", rom_addr, RST_PC);
    nxt(); nxt(); nxt(); #1;
    chk("rh_no_pend", rom_addr, 32'hBFC0_0008);
`ifdef FETCH_EXCEPT_EN
    // exception during stall with a redirect pending
    do_reset();
    nxt(); nxt();
    branch_flag = 1'b1;
    branch_addr = 32'hBFC0_0200;
    rom_ready = 1'b0;
    nxt();
    branch_flag = 1'b0;
    stall = 1'b1;
    exc_flag = 1'b1;
    exc_addr = 32'hBFC0_0380;
    nxt();
    exc_flag = 1'b0;
    stall = 1'b0;
    rom_ready = 1'b1;
    #1;
    chk("exc_pc", rom_addr, 32'hBFC0_0380);
    chk("exc_valid", if_valid, 0);
    nxt(); #1;
    chk("exc_if", if_addr, 32'hBFC0_0380);
    chk("exc_no_pend", rom_addr, 32'hBFC0_0384);
`endif
    nxt(); nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
